// File: rtl/bus_sync_pkg.sv
// -----------------------------------------------------------------------------
// bus_sync_pkg
// Shared definitions for the multi-bit bus synchronizer (slow-to-fast path).
//   state_t      : launcher FSM encoding
//   WIDTH        : default data bus width
//   NUM_STAGES   : default flop count of single-bit synchronizers
//   TIMEOUT_CYC  : default handshake wait limit (used only with ACK_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package bus_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETUP   = 2'b01,
        REQ     = 2'b10,
        RELEASE = 2'b11
    } state_t;

    localparam int WIDTH       = 8;
    localparam int NUM_STAGES  = 2;
    localparam int TIMEOUT_CYC = 255;

endpackage

// File: rtl/bus_sync_tx_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Single-bit level synchronizer built from NUM_Stages flops (NUM_Stages >= 2).
// Reusable by both the launch and receive sides of the bus synchronizer.
// Ports:
//   CLK          in   destination clock of this synchronizer, rising edge
//   Reset        in   asynchronous, active-low reset (all flops cleared to 0)
//   async_level  in   level from the foreign clock domain
//   level_sync   out  synchronized level (last flop)
//   level_next   out  value level_sync takes on the next edge (penultimate flop)
// -----------------------------------------------------------------------------
module bit_sync #(
    parameter int NUM_Stages = 2
) (
    input  logic CLK,
    input  logic Reset,
    input  logic async_level,
    output logic level_sync,
    output logic level_next
);

    logic [NUM_Stages-1:0] sync_ff;

    // Plain shift chain; only the first flop may go metastable.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[NUM_Stages-2:0], async_level};
        end
    end

    assign level_sync = sync_ff[NUM_Stages-1];
    // Lets a consumer register a decision that depends on the upcoming value.
    assign level_next = sync_ff[NUM_Stages-2];

endmodule

// File: rtl/bus_sync_tx.sv
// -----------------------------------------------------------------------------
// bus_sync_tx
// Source-domain launcher of the slow-to-fast multi-bit bus synchronizer.
// Captures a word on a valid/ready handshake, drives it on a registered bus and
// runs a 4-phase req/ack handshake (bus_EN = request, ack_async = acknowledge).
// The bus is stable one full cycle before the request rises and is held until
// the synchronized acknowledge has returned low.
// Optional build macro: ACK_TIMEOUT_EN (bounds waits in REQ and RELEASE).
// Ports:
//   CLK          in   source clock, rising edge
//   Reset        in   asynchronous, active-low reset
//   src_data     in   word to send, sampled when src_valid & src_ready
//   src_valid    in   source has a word
//   src_ready    out  block can accept a word (registered)
//   Async_bus    out  registered bus to the destination domain
//   bus_EN       out  request level to the destination
//   ack_async    in   acknowledge level from the destination (asynchronous)
//   tx_done      out  one-cycle pulse when a handshake completes
//   busy         out  high whenever the FSM is not in IDLE
//   err_timeout  out  one-cycle pulse on a handshake abort (0 without macro)
// -----------------------------------------------------------------------------
module bus_sync_tx #(
    parameter int Width       = bus_sync_pkg::WIDTH,
    parameter int NUM_Stages  = bus_sync_pkg::NUM_STAGES,
    parameter int TIMEOUT_CYC = bus_sync_pkg::TIMEOUT_CYC
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [Width-1:0] src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic [Width-1:0] Async_bus,
    output logic             bus_EN,
    input  logic             ack_async,
    output logic             tx_done,
    output logic             busy,
    output logic             err_timeout
);

    import bus_sync_pkg::*;

    state_t state;
    state_t next_state;
    logic   ack_sync;
    logic   ack_sync_next;
    logic   accept;
    logic   done_next;

    bit_sync #(
        .NUM_Stages (NUM_Stages)
    ) u_ack_sync (
        .CLK         (CLK),
        .Reset       (Reset),
        .async_level (ack_async),
        .level_sync  (ack_sync),
        .level_next  (ack_sync_next)
    );

    assign accept = (state == IDLE) && src_valid && src_ready;

`ifdef ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             err_next;

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC));

    // Restart the count on every entry into a wait state.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if ((next_state != state) &&
                     ((next_state == REQ) || (next_state == RELEASE))) begin
            wait_cnt <= '0;
        end else if ((state == REQ) || (state == RELEASE)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= err_next;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    // Next-state logic; the FSM only ever looks at the synchronized ack.
    always_comb begin
        next_state = state;
        done_next  = 1'b0;
`ifdef ACK_TIMEOUT_EN
        err_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = REQ;
            end
            REQ: begin
                if (ack_sync) begin
                    next_state = RELEASE;
                end
`ifdef ACK_TIMEOUT_EN
                else if (timeout_hit) begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!ack_sync) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
`ifdef ACK_TIMEOUT_EN
                else if (timeout_hit) begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // All outputs are registered from next_state so they change glitch-free.
    // src_ready also waits for a stale acknowledge to clear before reopening.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            Async_bus <= '0;
            bus_EN    <= 1'b0;
            src_ready <= 1'b0;
            tx_done   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            bus_EN    <= (next_state == REQ);
            busy      <= (next_state != IDLE);
            src_ready <= (next_state == IDLE) && !ack_sync_next;
            tx_done   <= done_next;
            if (accept) begin
                Async_bus <= src_data;
            end
        end
    end

endmodule

// File: tb/tb_bus_sync_tx.sv
// -----------------------------------------------------------------------------
// tb_bus_sync_tx
// Self-checking bench for bus_sync_tx. Words are pushed to a scoreboard queue
// when offered and popped when the request rises; the acknowledge is driven
// by the bench acting as the destination domain.
// -----------------------------------------------------------------------------
module tb_bus_sync_tx;

    localparam int WIDTH      = 8;
    localparam int NUM_STAGES = 2;
`ifdef ACK_TIMEOUT_EN
    localparam int TIMEOUT    = 8;
`else
    localparam int TIMEOUT    = 255;
`endif

    logic             CLK = 1'b0;
    logic             Reset = 1'b0;
    logic [WIDTH-1:0] src_data = '0;
    logic             src_valid = 1'b0;
    logic             src_ready;
    logic [WIDTH-1:0] Async_bus;
    logic             bus_EN;
    logic             ack_async = 1'b0;
    logic             tx_done;
    logic             busy;
    logic             err_timeout;

    int total = 0;
    int bad   = 0;
    int txPulses  = 0;
    int errPulses = 0;
    int expDone   = 0;

    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] heldWord = '0;
    logic             inHs = 1'b0;
    logic             prevEn = 1'b0;

    bus_sync_tx #(
        .Width       (WIDTH),
        .NUM_Stages  (NUM_STAGES),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .Async_bus   (Async_bus),
        .bus_EN      (bus_EN),
        .ack_async   (ack_async),
        .tx_done     (tx_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: the word on the bus at request rise must be the next
    // offered word, and it must not move until the handshake ends.
    always @(negedge CLK) begin
        if (!Reset) begin
            inHs   = 1'b0;
            prevEn = 1'b0;
        end else begin
            if (bus_EN && !prevEn) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_req", 32'd1, 32'd0);
                end else begin
                    heldWord = expQ.pop_front();
                    checkOutput("bus_capture", 32'(Async_bus), 32'(heldWord));
                    inHs = 1'b1;
                end
            end else if (inHs) begin
                checkOutput("bus_stable", 32'(Async_bus), 32'(heldWord));
            end
            if (tx_done)     txPulses++;
            if (err_timeout) errPulses++;
            if (tx_done || err_timeout) inHs = 1'b0;
            prevEn = bus_EN;
        end
    end

    // Offer a word starting at a negedge and wait for it to be taken; returns
    // at the negedge right after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit holdValid,
                                 input logic [WIDTH-1:0] nextWord);
        int n;
        expQ.push_back(word);
        src_data  = word;
        src_valid = 1'b1;
        n = 0;
        while (!src_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("accept_wait", 32'(src_ready), 32'd1);
        @(posedge CLK);
        #1;
        if (holdValid) src_data = nextWord;
        else           src_valid = 1'b0;
        @(negedge CLK);
        checkOutput("setup_bus", 32'(Async_bus), 32'(word));
        checkOutput("setup_no_req", 32'(bus_EN), 32'd0);
        checkOutput("setup_busy", 32'(busy), 32'd1);
        checkOutput("setup_not_ready", 32'(src_ready), 32'd0);
        checkOutput("setup_no_done", 32'(tx_done), 32'd0);
    endtask

    // Act as the destination: ack the request, then release it; returns at the
    // negedge where tx_done is seen.
    task automatic runHandshake(input logic [WIDTH-1:0] word);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus_EN && n < 50);
        checkOutput("req_after_setup", 32'(n), 32'd1);
        if (!bus_EN) return;
        checkOutput("req_bus", 32'(Async_bus), 32'(word));
        ack_async = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus_EN && n < 50);
        checkOutput("req_fall_edges", 32'(n), 32'(NUM_STAGES + 1));
        checkOutput("release_busy", 32'(busy), 32'd1);
        checkOutput("release_no_done", 32'(tx_done), 32'd0);
        ack_async = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!tx_done && n < 50);
        checkOutput("done_edges", 32'(n), 32'(NUM_STAGES + 1));
        checkOutput("done_ready", 32'(src_ready), 32'd1);
        checkOutput("done_idle", 32'(busy), 32'd0);
        checkOutput("done_bus_kept", 32'(Async_bus), 32'(word));
        expDone++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("reset_outputs",
                        32'({src_ready, bus_EN, tx_done, busy, err_timeout, Async_bus}), 32'd0);
        end
        #1 Reset = 1'b1;
        @(negedge CLK);
        checkOutput("ready_after_reset", 32'(src_ready), 32'd1);
        checkOutput("idle_no_req", 32'(bus_EN), 32'd0);
        checkOutput("idle_not_busy", 32'(busy), 32'd0);

        // Single transfer
        applyStimulus(8'hA5, 1'b0, 8'h00);
        runHandshake(8'hA5);
        @(negedge CLK);
        checkOutput("done_single_pulse", 32'(tx_done), 32'd0);
        checkOutput("ready_stays", 32'(src_ready), 32'd1);

        // Back-to-back with src_valid held
        applyStimulus(8'hA5, 1'b1, 8'h3C);
        runHandshake(8'hA5);
        applyStimulus(8'h3C, 1'b0, 8'h00);
        runHandshake(8'h3C);
        @(negedge CLK);

        // Stale acknowledge in IDLE
        ack_async = 1'b1;
        repeat (NUM_STAGES + 2) @(negedge CLK);
        checkOutput("stale_not_ready", 32'(src_ready), 32'd0);
        src_data  = 8'h77;
        src_valid = 1'b1;
        repeat (6) @(negedge CLK);
        checkOutput("stale_no_capture", 32'(Async_bus), 32'h3C);
        checkOutput("stale_no_req", 32'(bus_EN), 32'd0);
        checkOutput("stale_idle", 32'(busy), 32'd0);
        ack_async = 1'b0;
        applyStimulus(8'h77, 1'b0, 8'h00);
        runHandshake(8'h77);
        @(negedge CLK);

        // Reset in the middle of REQ
        expQ.push_back(8'hC3);
        src_data  = 8'hC3;
        src_valid = 1'b1;
        @(posedge CLK);
        #1 src_valid = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("midreq_req_up", 32'(bus_EN), 32'd1);
        #2 Reset = 1'b0;
        #1;
        checkOutput("midreq_req_drop", 32'(bus_EN), 32'd0);
        checkOutput("midreq_bus_clear", 32'(Async_bus), 32'd0);
        checkOutput("midreq_busy_clear", 32'(busy), 32'd0);
        repeat (3) @(negedge CLK);
        #1 Reset = 1'b1;
        @(negedge CLK);
        applyStimulus(8'h5A, 1'b0, 8'h00);
        runHandshake(8'h5A);
        @(negedge CLK);

`ifdef ACK_TIMEOUT_EN
        // Acknowledge never arrives
        begin
            int n;
            int txBefore;
            txBefore = txPulses;
            applyStimulus(8'hE1, 1'b0, 8'h00);
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!err_timeout && n < 100);
            checkOutput("timeout_pulse", 32'(err_timeout), 32'd1);
            checkOutput("timeout_cycles", 32'(n), 32'(TIMEOUT + 2));
            checkOutput("timeout_req_drop", 32'(bus_EN), 32'd0);
            checkOutput("timeout_idle", 32'(busy), 32'd0);
            checkOutput("timeout_no_done", 32'(tx_done), 32'd0);
            @(negedge CLK);
            checkOutput("timeout_single", 32'(err_timeout), 32'd0);
            checkOutput("timeout_ready", 32'(src_ready), 32'd1);
            checkOutput("timeout_tx_count", 32'(txPulses - txBefore), 32'd0);
        end
        checkOutput("err_pulse_total", 32'(errPulses), 32'd1);
`else
        checkOutput("err_never", 32'(errPulses), 32'd0);
`endif

        checkOutput("tx_done_total", 32'(txPulses), 32'(expDone));
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
